// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t : FSM state encoding (IDLE, RUN, DONE)
//   clog2   : bits needed to hold values 0..value-1 (step counter width uses clog2(WIDTH+1))
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; constant-evaluable so it can size localparams.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_step.sv
// One shift-add partial-product step (combinational).
//   acc      : current 2*WIDTH accumulator
//   mcand    : multiplicand magnitude
//   mbit     : current multiplier bit
//   step     : step index, aligns the multiplicand
//   acc_next : accumulator after this step
module pp_step #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    input  logic [CW-1:0]      step,
    output logic [2*WIDTH-1:0] acc_next
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] addend;

    always_comb begin
        addend   = PW'(mcand) << step;
        acc_next = mbit ? (acc + addend) : acc;
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential WIDTH x WIDTH multiplier, one shift-add step per clock,
// unsigned or two's-complement operands selected at start.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a multiply (accepted in IDLE or DONE)
//   signed_mode : 1 = two's complement operands, 0 = unsigned
//   a, b        : multiplicand, multiplier
//   busy        : high while the multiply runs (WIDTH cycles)
//   done        : one-cycle pulse when p is newly valid
//   p           : 2*WIDTH product register
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = clog2(WIDTH + 1);

    state_t          state;
    state_t          state_next;
    logic            accept_c;
    logic            last_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic            neg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next_c;
    logic [CW-1:0]   cnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, read as unsigned 2^(WIDTH-1)
    always_comb begin
        a_mag_c = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag_c = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    pp_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pp_step (
        .acc      (acc),
        .mcand    (mcand),
        .mbit     (mplier[0]),
        .step     (cnt),
        .acc_next (acc_next_c)
    );

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept_c) begin
                mcand  <= a_mag_c;
                mplier <= b_mag_c;
                neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_next_c;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last_c) begin
                    p <= neg ? -acc_next_c : acc_next_c;
                end
            end
        end
    end

endmodule
